// File: rtl/spike_event_fifo.sv
// Turns rising edges of a neuron spike flag into {timestamp, ISI, first} records and
// buffers them in a show-ahead FIFO drained over a valid/ready handshake.
module spike_event_fifo #(
  parameter int unsigned TS_W    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned MIN_ISI = 0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              spike,
  input  logic              clear_overflow,
  input  logic              ev_ready,
  output logic              ev_valid,
  output logic [TS_W-1:0]   ev_timestamp,
  output logic [TS_W-1:0]   ev_isi,
  output logic              ev_first,
  output logic [$clog2(DEPTH):0] level,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] isi;
    logic            first;
  } rec_t;

  logic [TS_W-1:0] ts_q, last_ts_q;
  logic            spike_q, have_prev_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_count_q, drop_count_d;
  rec_t            mem_q [DEPTH];

  logic            spike_edge, suppress, accept, pop, push, drop, full;
  logic [TS_W-1:0] isi_raw;
  rec_t            new_rec, head;

  assign spike_edge = spike & ~spike_q;
  assign isi_raw    = ts_q - last_ts_q;

  // A zero window disables the refractory check entirely.
  if (MIN_ISI == 0) begin : g_no_refr
    assign suppress = 1'b0;
  end else begin : g_refr
    assign suppress = have_prev_q & (isi_raw < TS_W'(MIN_ISI));
  end

  assign accept = spike_edge & ~suppress;
  assign full   = (level_q == LW'(DEPTH));
  assign pop    = ev_valid & ev_ready;
  assign push   = accept & (~full | pop);
  assign drop   = accept & full & ~pop;

  assign new_rec.ts    = ts_q;
  assign new_rec.isi   = have_prev_q ? isi_raw : '0;
  assign new_rec.first = ~have_prev_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ts_q         <= '0;
      spike_q      <= 1'b0;
      last_ts_q    <= '0;
      have_prev_q  <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      spike_q <= spike;
      if (enable) begin
        ts_q <= ts_q + TS_W'(1);
      end
      // Dropped records still advance last_ts so the ISI tracks real spike spacing.
      if (accept) begin
        last_ts_q   <= ts_q;
        have_prev_q <= 1'b1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_rec;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign ev_valid     = (level_q != '0);
  assign ev_timestamp = ev_valid ? head.ts : '0;
  assign ev_isi       = ev_valid ? head.isi : '0;
  assign ev_first     = ev_valid & head.first;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign drop_count   = drop_count_q;

endmodule
